qtr_line_error: RTL and testbench
=================================

// Module: qtr_line_error
// PURPOSE
//  Stage directly downstream of the QTR position summer: converts its weighted sum SP and active-sensor count SN
//  into a line centroid pos = SP/SN (sensor pitch units, 10..80) and a signed steering error vs. a setpoint.
//  Uses a sequential restoring divider; detects line loss with a debounce and saturates the error toward the last-seen side.
//  Output feeds the PID/motor controller.
// PARAMETERS
//  SETPOINT   45   centre position (midway between sensors 4 and 5, weights 10..80)
//  MAX_ERR    64   error magnitude reported while the line is lost (positive value)
//  LOST_CNT   3    consecutive SN==0 samples required before lost asserts (1..15)
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   synchronous reset, active-low (sampled on rising clk edge)
//  stb        in   1   sample strobe: SP/SN valid this cycle, one-cycle pulse
//  SP         in   16  weighted position sum from the summer
//  SN         in   5   number of active sensors (0..8)
//  pos        out  8   latest centroid, unsigned
//  err        out  9   signed two's complement error = pos - SETPOINT, or +/-MAX_ERR when lost
//  valid      out  1   one-cycle pulse when pos/err/lost have updated
//  lost       out  1   line-lost flag
//  busy       out  1   high while a sample is in flight (stb ignored)
//  overrun    out  1   sticky: a stb arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, pos=SETPOINT, err=0, valid=0, lost=0, busy=0, overrun=0, zero_cnt=0,
//   last_side=0; takes effect even mid-division, in-flight sample discarded, no valid pulse.
//  FSM IDLE -> LOAD -> (DIV x16) -> DONE -> IDLE.
//   IDLE: stb=1 captures SP, SN into registers; -> LOAD. busy rises the cycle after capture.
//   LOAD: SN==0 -> DONE (zero path); else init remainder=0, quotient=SP, bit counter=15; -> DIV.
//   DIV: one restoring step per cycle, MSB first (shift, trial-subtract 5-bit divisor, set quotient bit); after 16 steps -> DONE.
//   DONE: update outputs, valid=1 for this one cycle, busy=0 next cycle; -> IDLE.
//  Latency: valid 18 clocks after the stb edge (divide path); 2 clocks (zero path). Throughput one sample per 19 clocks max.
//  stb while busy (LOAD/DIV/DONE): sample dropped, overrun set; no effect on the in-flight result.
//  Divide path (SN!=0): pos = floor(SP/SN), saturated to 255 if quotient > 255 (unreachable with legal inputs);
//   err = pos - SETPOINT computed in 10 bits, clamped to [-256,255]; zero_cnt=0; lost=0;
//   last_side = (pos < SETPOINT) ? 0 (left) : 1 (right).
//  Zero path (SN==0): zero_cnt increments (saturates at LOST_CNT); pos held.
//   zero_cnt < LOST_CNT: err, lost held. zero_cnt reaches LOST_CNT: lost=1,
//   err = last_side ? +MAX_ERR : -MAX_ERR. Held until next SN!=0 sample, which clears lost in the same DONE.
//  All outputs registered; SP/SN need only be stable in the stb cycle.
// STRUCTURE
//  Shared package qtr_pkg: SP_W=16, SN_W=5, POS_W=8, ERR_W=9, FSM state enum (IDLE, LOAD, DIV, DONE).
//  One sub-module: qtr_seq_div (16-bit / 5-bit unsigned restoring divider with start/done); the
//  parent holds the FSM, lost debounce, error and saturation logic.
// TESTING
//  1. SP=90, SN=2 on stb -> valid exactly 18 clocks later, pos=45, err=0, lost=0, busy high in between.
//  2. SP=150, SN=2 -> pos=75, err=+30; then SP=10, SN=3 -> pos=3 (truncated), err=-42.
//  3. After pos=20, three stb with SN=0 (LOST_CNT=3) -> first two: valid after 2 clocks, err=-25 held,
//     lost=0; third: lost=1, err=-64; next SP=80, SN=1 -> pos=80, err=+35, lost=0.
//  4. stb with SP=120, SN=3, second stb 5 clocks later -> second ignored, overrun=1, result pos=40, err=-5.
//  5. rst=0 asserted at clock 8 of a division -> no valid pulse, all outputs at reset values next edge;
//     new stb after rst=1 completes normally.
//  6. SP=360, SN=8 (all sensors) -> pos=45, err=0; SP=0xFFFF, SN=1 -> pos=255, err=+210.

Source files
------------

// File: rtl/qtr_pkg.sv
// Shared widths, FSM state encoding and error clamp for the QTR line-error stage.
package qtr_pkg;
  localparam int SP_W  = 16;
  localparam int SN_W  = 5;
  localparam int POS_W = 8;
  localparam int ERR_W = 9;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  // Narrow a 10-bit signed difference to the 9-bit error range.
  function automatic logic [ERR_W-1:0] clamp_err(input logic signed [ERR_W:0] e);
    if (e > 10'sd255)       return 9'h0FF;
    else if (e < -10'sd256) return 9'h100;
    else                    return e[ERR_W-1:0];
  endfunction
endpackage

// File: rtl/qtr_seq_div.sv
// 16-bit / 5-bit unsigned restoring divider, one quotient bit per clock, MSB first.
module qtr_seq_div
  import qtr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SP_W-1:0] dividend,
  input  logic [SN_W-1:0] divisor,
  output logic            last,
  output logic [SP_W-1:0] quot
);
  logic [SN_W-1:0] rem;
  logic [3:0]      cnt;
  logic            run;
  logic [SN_W:0]   rem_sh;
  logic [SN_W+1:0] diff;
  logic            ge;

  assign rem_sh = {rem, quot[SP_W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, divisor};
  assign ge     = ~diff[SN_W+1];
  // High during the cycle whose edge writes the final quotient bit.
  assign last   = run && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      run  <= 1'b0;
      cnt  <= 4'd0;
      rem  <= '0;
      quot <= '0;
    end else if (start) begin
      run  <= 1'b1;
      cnt  <= 4'd15;
      rem  <= '0;
      quot <= dividend;
    end else if (run) begin
      rem  <= ge ? diff[SN_W-1:0] : rem_sh[SN_W-1:0];
      quot <= {quot[SP_W-2:0], ge};
      if (cnt == 4'd0) run <= 1'b0;
      else             cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/qtr_line_error.sv
// Line centroid and steering error from QTR summer output, with debounced line-loss saturation.
module qtr_line_error
  import qtr_pkg::*;
#(
  parameter int SETPOINT = 45,
  parameter int MAX_ERR  = 64,
  parameter int LOST_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stb,
  input  logic [SP_W-1:0]         SP,
  input  logic [SN_W-1:0]         SN,
  output logic [POS_W-1:0]        pos,
  output logic signed [ERR_W-1:0] err,
  output logic                    valid,
  output logic                    lost,
  output logic                    busy,
  output logic                    overrun
);
  state_t            state;
  logic [SP_W-1:0]   sp_r;
  logic [SN_W-1:0]   sn_r;
  logic [3:0]        zero_cnt;
  logic [3:0]        zero_inc;
  logic              last_side;
  logic              div_start;
  logic              div_last;
  logic [SP_W-1:0]   quot;
  logic [POS_W-1:0]  pos_q;
  logic signed [ERR_W:0] diff;

  assign div_start = (state == LOAD) && (sn_r != '0);
  assign pos_q     = (|quot[SP_W-1:POS_W]) ? {POS_W{1'b1}} : quot[POS_W-1:0];
  assign diff      = $signed({2'b00, pos_q}) - $signed(10'(SETPOINT));
  assign zero_inc  = (zero_cnt == 4'(LOST_CNT)) ? zero_cnt : zero_cnt + 4'd1;

  qtr_seq_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sp_r),
    .divisor  (sn_r),
    .last     (div_last),
    .quot     (quot)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sp_r      <= '0;
      sn_r      <= '0;
      pos       <= POS_W'(SETPOINT);
      err       <= '0;
      valid     <= 1'b0;
      lost      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      zero_cnt  <= '0;
      last_side <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (stb && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (stb) begin
          sp_r  <= SP;
          sn_r  <= SN;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD: state <= (sn_r == '0) ? DONE : DIV;
        DIV:  if (div_last) state <= DONE;
        DONE: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (sn_r != '0) begin
            pos       <= pos_q;
            err       <= clamp_err(diff);
            lost      <= 1'b0;
            zero_cnt  <= '0;
            last_side <= (pos_q >= POS_W'(SETPOINT));
          end else begin
            zero_cnt <= zero_inc;
            // Lost holds at the saturated count; error points to the side the line left by.
            if (zero_inc == 4'(LOST_CNT)) begin
              lost <= 1'b1;
              err  <= last_side ? ERR_W'(MAX_ERR) : ERR_W'(-MAX_ERR);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qtr_line_error.sv
// Directed scoreboard bench for qtr_line_error: expected results queued on stb, checked on valid.
module tb_qtr_line_error;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               stb = 1'b0;
  logic [15:0]        SP  = '0;
  logic [4:0]         SN  = '0;
  logic [7:0]         pos;
  logic signed [8:0]  err;
  logic               valid, lost, busy, overrun;

  qtr_line_error dut (
    .clk(clk), .rst(rst), .stb(stb), .SP(SP), .SN(SN),
    .pos(pos), .err(err), .valid(valid), .lost(lost),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        pos;
    logic signed [8:0] err;
    logic              lost;
    int                at;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int                m_zc;
  logic [7:0]        m_pos;
  logic signed [8:0] m_err;
  logic              m_lost, m_side;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pos", int'(pos), int'(e.pos));
        chk("err", int'(err), int'(e.err));
        chk("lost", int'(lost), int'(e.lost));
        chk("latency", cyc, e.at);
      end
    end
  end

  task automatic model_reset();
    m_zc = 0; m_pos = 8'd45; m_err = 9'sd0; m_lost = 1'b0; m_side = 1'b0;
  endtask

  // Drives one stb pulse; if accepted, the expected result is queued.
  task automatic send(input int sp, input int sn, input bit accepted);
    @(negedge clk);
    stb = 1'b1; SP = 16'(sp); SN = 5'(sn);
    if (accepted) begin
      exp_t e;
      if (sn != 0) begin
        int qv;
        qv = sp / sn;
        m_pos = (qv > 255) ? 8'd255 : 8'(qv);
        m_err = 9'(int'(m_pos) - 45);
        m_lost = 1'b0; m_zc = 0; m_side = (m_pos >= 8'd45);
      end else begin
        if (m_zc < 3) m_zc++;
        if (m_zc == 3) begin
          m_lost = 1'b1;
          m_err = m_side ? 9'sd64 : -9'sd64;
        end
      end
      e.pos = m_pos; e.err = m_err; e.lost = m_lost;
      e.at = cyc + 1 + ((sn != 0) ? 18 : 2);
      q.push_back(e);
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pos", int'(pos), 45);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_lost", int'(lost), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    @(negedge clk);

    // Centre sample with busy window
    send(90, 2, 1);
    chk("busy_start", int'(busy), 1);
    repeat (16) @(negedge clk);
    chk("busy_late", int'(busy), 1);
    drain();
    chk("busy_after", int'(busy), 0);
    chk("valid_pulse", int'(valid), 0);

    send(150, 2, 1); drain();
    send(10, 3, 1);  drain();

    // Line loss debounce and recovery
    send(40, 2, 1); drain();
    send(0, 0, 1);  drain();
    send(0, 0, 1);  drain();
    send(0, 0, 1);  drain();
    send(0, 0, 1);  drain();
    send(80, 1, 1); drain();

    // stb while busy is dropped
    chk("overrun_pre", int'(overrun), 0);
    send(120, 3, 1);
    repeat (3) @(negedge clk);
    send(77, 7, 0);
    drain();
    chk("overrun_set", int'(overrun), 1);

    // Reset in the middle of a division
    send(200, 4, 1);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_pos", int'(pos), 45);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_lost", int'(lost), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    model_reset();
    repeat (25) @(negedge clk);
    send(100, 2, 1); drain();

    // Full sensor count and oversized quotient
    send(360, 8, 1);   drain();
    send(65535, 1, 1); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
